// File: rtl/bin_analyzer_pkg.sv
// Shared definitions for bin_analyzer: parameter defaults, accumulator width,
// FSM state encoding and the sine-table entry generator.
package bin_analyzer_pkg;

    localparam int SIZE_DEF   = 16;
    localparam int N_LOG2_DEF = 11;

    localparam real PI = 3.14159265358979323846;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Enough headroom for N full-scale products without wrap in practice.
    function automatic int acc_w(input int size, input int n_log2);
        return 2 * size + n_log2;
    endfunction

    // Elaboration-time only: round((2^(size-1)-1) * sin(2*pi*idx/N)), ties away from zero.
    function automatic int sine_entry(input int idx, input int size, input int n_log2);
        real amp;
        real x;
        amp = real'((1 << (size - 1)) - 1);
        x   = amp * $sin(2.0 * PI * real'(idx) / real'(1 << n_log2));
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    endfunction

endpackage

// File: rtl/bin_analyzer_if.sv
// Control, sample stream and result bus of bin_analyzer; master drives
// stimulus, slave is the analyzer.
interface bin_analyzer_if
    import bin_analyzer_pkg::*;
#(
    parameter int SIZE   = SIZE_DEF,
    parameter int N_LOG2 = N_LOG2_DEF
);
    localparam int ACC_W = acc_w(SIZE, N_LOG2);

    logic                    start;
    logic                    clr;
    logic [N_LOG2-1:0]       bin;
    logic                    in_valid;
    logic signed [SIZE-1:0]  sample;
    logic                    in_ready;
    logic                    busy;
    logic                    done;
    logic signed [ACC_W-1:0] re_out;
    logic signed [ACC_W-1:0] im_out;
    logic [ACC_W:0]          mag_out;

    modport master (
        output start, clr, bin, in_valid, sample,
        input  in_ready, busy, done, re_out, im_out, mag_out
    );

    modport slave (
        input  start, clr, bin, in_valid, sample,
        output in_ready, busy, done, re_out, im_out, mag_out
    );

endinterface

// File: rtl/bin_analyzer_quad_sine_table.sv
// N-entry signed sine ROM with two combinational read ports; contents are
// fixed at elaboration from the rounded full-scale sine.
module quad_sine_table
    import bin_analyzer_pkg::*;
#(
    parameter int SIZE   = SIZE_DEF,
    parameter int N_LOG2 = N_LOG2_DEF
) (
    input  logic [N_LOG2-1:0]      addr_a,
    input  logic [N_LOG2-1:0]      addr_b,
    output logic signed [SIZE-1:0] data_a,
    output logic signed [SIZE-1:0] data_b
);
    localparam int N = 1 << N_LOG2;

    logic signed [SIZE-1:0] rom [N];

    for (genvar i = 0; i < N; i++) begin : g_rom
        localparam logic signed [SIZE-1:0] VAL = SIZE'(sine_entry(i, SIZE, N_LOG2));
        assign rom[i] = VAL;
    end

    assign data_a = rom[addr_a];
    assign data_b = rom[addr_b];

endmodule

// File: rtl/bin_analyzer.sv
// Single-bin DFT (Goertzel-free direct correlation) over an N-sample frame.
// Optional magnitude stage enabled by defining BIN_ANALYZER_MAG_EN.
module bin_analyzer
    import bin_analyzer_pkg::*;
#(
    parameter int SIZE   = SIZE_DEF,
    parameter int N_LOG2 = N_LOG2_DEF
) (
    input  logic          clk,
    input  logic          rst,
    bin_analyzer_if.slave bus
);
    localparam int ACC_W  = acc_w(SIZE, N_LOG2);
    localparam int PROD_W = 2 * SIZE;
    localparam logic [N_LOG2-1:0] QUARTER = N_LOG2'(1 << (N_LOG2 - 2));
`ifdef BIN_ANALYZER_MAG_EN
    localparam logic [1:0] DRAIN_LAST = 2'd2;
`else
    localparam logic [1:0] DRAIN_LAST = 2'd1;
`endif

    state_e                   state_q, state_d;
    logic [N_LOG2-1:0]        bin_q, bin_d;
    logic [N_LOG2-1:0]        n_q, n_d;
    logic [N_LOG2-1:0]        phase_q, phase_d;
    logic [1:0]               drain_q, drain_d;
    logic                     prod_vld_q, prod_vld_d;
    logic signed [PROD_W-1:0] prod_re_q, prod_re_d;
    logic signed [PROD_W-1:0] prod_im_q, prod_im_d;
    logic signed [ACC_W-1:0]  acc_re_q, acc_re_d;
    logic signed [ACC_W-1:0]  acc_im_q, acc_im_d;

    logic signed [SIZE-1:0]   sin_val, cos_val;
    logic [N_LOG2-1:0]        cos_addr;
    logic signed [PROD_W-1:0] smp_ext, sin_ext, cos_ext;
    logic                     accept;

    assign cos_addr = phase_q + QUARTER;

    quad_sine_table #(
        .SIZE   (SIZE),
        .N_LOG2 (N_LOG2)
    ) u_sine (
        .addr_a (phase_q),
        .addr_b (cos_addr),
        .data_a (sin_val),
        .data_b (cos_val)
    );

    assign accept  = bus.in_valid && (state_q == ST_ACCUM);
    // Operands widened first so the low PROD_W bits hold the exact signed product.
    assign smp_ext = $signed({{SIZE{bus.sample[SIZE-1]}}, bus.sample});
    assign sin_ext = $signed({{SIZE{sin_val[SIZE-1]}}, sin_val});
    assign cos_ext = $signed({{SIZE{cos_val[SIZE-1]}}, cos_val});

    // NOTE: every output of this block is given a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        n_d        = n_q;
        phase_d    = phase_q;
        drain_d    = drain_q;
        prod_vld_d = 1'b0;
        prod_re_d  = prod_re_q;
        prod_im_d  = prod_im_q;
        acc_re_d   = acc_re_q;
        acc_im_d   = acc_im_q;

        if (prod_vld_q) begin
            acc_re_d = acc_re_q + {{(ACC_W-PROD_W){prod_re_q[PROD_W-1]}}, prod_re_q};
            acc_im_d = acc_im_q + {{(ACC_W-PROD_W){prod_im_q[PROD_W-1]}}, prod_im_q};
        end

        if (accept) begin
            prod_re_d  = smp_ext * cos_ext;
            prod_im_d  = smp_ext * sin_ext;
            prod_vld_d = 1'b1;
            phase_d    = phase_q + bin_q;
            n_d        = n_q + N_LOG2'(1);
        end

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d   = ST_ACCUM;
                    bin_d     = bus.bin;
                    n_d       = '0;
                    phase_d   = '0;
                    prod_re_d = '0;
                    prod_im_d = '0;
                    acc_re_d  = '0;
                    acc_im_d  = '0;
                end
            end
            ST_ACCUM: begin
                if (accept && (n_q == '1)) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end
            end
            ST_DRAIN: begin
                drain_d = drain_q + 2'd1;
                if (drain_q == DRAIN_LAST) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Abort wins over start, sample acceptance and pipeline flush alike.
        if (bus.clr) begin
            state_d    = ST_IDLE;
            n_d        = '0;
            phase_d    = '0;
            drain_d    = '0;
            prod_vld_d = 1'b0;
            prod_re_d  = '0;
            prod_im_d  = '0;
            acc_re_d   = '0;
            acc_im_d   = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bin_q      <= '0;
            n_q        <= '0;
            phase_q    <= '0;
            drain_q    <= '0;
            prod_vld_q <= 1'b0;
            prod_re_q  <= '0;
            prod_im_q  <= '0;
            acc_re_q   <= '0;
            acc_im_q   <= '0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            n_q        <= n_d;
            phase_q    <= phase_d;
            drain_q    <= drain_d;
            prod_vld_q <= prod_vld_d;
            prod_re_q  <= prod_re_d;
            prod_im_q  <= prod_im_d;
            acc_re_q   <= acc_re_d;
            acc_im_q   <= acc_im_d;
        end
    end

`ifdef BIN_ANALYZER_MAG_EN
    logic [ACC_W:0]        mag_q, mag_d;
    logic signed [ACC_W:0] re_ext, im_ext;
    logic [ACC_W:0]        re_abs, im_abs;

    always_comb begin
        re_ext = $signed({acc_re_q[ACC_W-1], acc_re_q});
        im_ext = $signed({acc_im_q[ACC_W-1], acc_im_q});
        re_abs = $unsigned(re_ext[ACC_W] ? -re_ext : re_ext);
        im_abs = $unsigned(im_ext[ACC_W] ? -im_ext : im_ext);
        mag_d  = mag_q;
        // Accumulators are final by the last drain cycle.
        if ((state_q == ST_DRAIN) && (drain_q == DRAIN_LAST)) mag_d = re_abs + im_abs;
        if (((state_q == ST_IDLE) && bus.start) || bus.clr) mag_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) mag_q <= '0;
        else     mag_q <= mag_d;
    end

    assign bus.mag_out = mag_q;
`else
    assign bus.mag_out = '0;
`endif

    assign bus.in_ready = (state_q == ST_ACCUM);
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.done     = (state_q == ST_DONE);
    assign bus.re_out   = acc_re_q;
    assign bus.im_out   = acc_im_q;

endmodule

// File: tb/tb_bin_analyzer.sv
// Self-checking bench for bin_analyzer: random frames compared against a
// direct DFT-sum reference built from the rounded sine table definition.
`timescale 1ns/1ps
module tb_bin_analyzer;

    localparam int SIZE   = 16;
    localparam int N_LOG2 = 11;
    localparam int N      = 2048;
    localparam int ACC_W  = 43;
`ifdef BIN_ANALYZER_MAG_EN
    localparam bit MAG_ON   = 1'b1;
    localparam int DONE_LAT = N + 3;
`else
    localparam bit MAG_ON   = 1'b0;
    localparam int DONE_LAT = N + 2;
`endif

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;
    int   sine [N];
    int   smp  [N];

    bin_analyzer_if #(.SIZE(SIZE), .N_LOG2(N_LOG2)) bus ();

    bin_analyzer #(.SIZE(SIZE), .N_LOG2(N_LOG2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: X[k] = sum x[n]*(cos, sin)(2*pi*k*n/N) using the rounded table.
    function automatic void model(input int k, output longint re, output longint im, output longint mag);
        int p;
        re = 0;
        im = 0;
        for (int n = 0; n < N; n++) begin
            p  = (k * n) % N;
            re += longint'(smp[n]) * longint'(sine[(p + N / 4) % N]);
            im += longint'(smp[n]) * longint'(sine[p]);
        end
        mag = MAG_ON ? ((re < 0 ? -re : re) + (im < 0 ? -im : im)) : 64'sd0;
    endfunction

    function automatic void fill_random();
        for (int n = 0; n < N; n++) smp[n] = int'($urandom_range(65535, 0)) - 32768;
    endfunction

    // Drives one frame from smp[]; reports done latency from the first accept cycle.
    task automatic run_frame(input int k, input bit stall, input bit poke_start,
                             output int lat, output bit got_done, output bit rdy_after);
        int idx;
        int t;
        int t0;
        int tlast;
        bit presented;
        lat = -1; got_done = 1'b0; rdy_after = 1'b1;
        t0 = -1; tlast = -10; idx = 0; t = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = N_LOG2'(k);
        @(negedge clk);
        bus.start = 1'b0;
        while (!got_done && t < 3 * N + 64) begin
            if (bus.done) begin
                got_done = 1'b1;
                lat      = t - t0;
            end else begin
                if (idx == N && t == tlast + 1) rdy_after = bus.in_ready;
                presented    = (idx < N) && (!stall || (t % 2 == 0));
                bus.in_valid = presented;
                bus.sample   = presented ? SIZE'(smp[idx]) : '0;
                bus.start    = poke_start && (t % 97 == 5);
                bus.bin      = poke_start ? N_LOG2'(k + 3) : N_LOG2'(k);
                if (presented && bus.in_ready) begin
                    if (idx == 0) t0 = t;
                    if (idx == N - 1) tlast = t;
                    idx++;
                end
                @(negedge clk);
                t++;
            end
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests_run += 6;
        if (bus.in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
        if (bus.busy !== 1'b0)     begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        if (bus.done !== 1'b0)     begin tests_failed++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        if (bus.re_out !== '0)     begin tests_failed++; $display("FAIL reset_re: got %0d expected 0", bus.re_out); end
        if (bus.im_out !== '0)     begin tests_failed++; $display("FAIL reset_im: got %0d expected 0", bus.im_out); end
        if (bus.mag_out !== '0)    begin tests_failed++; $display("FAIL reset_mag: got %0d expected 0", bus.mag_out); end
        rst = 1'b0;
    endtask

    task automatic test_dc();
        int     lat;
        bit     gd, ra;
        longint exp_re, exp_mag;
        for (int n = 0; n < N; n++) smp[n] = 32'h1000;
        exp_re  = 64'd274869518336;
        exp_mag = MAG_ON ? 64'd274869518336 : 64'd0;
        run_frame(0, 1'b0, 1'b0, lat, gd, ra);
        tests_run += 5;
        if (!gd)                           begin tests_failed++; $display("FAIL dc_done: no done pulse seen"); end
        if (lat != DONE_LAT)               begin tests_failed++; $display("FAIL dc_latency: got %0d expected %0d", lat, DONE_LAT); end
        if (bus.re_out !== ACC_W'(exp_re)) begin tests_failed++; $display("FAIL dc_re: got %0d expected %0d", bus.re_out, exp_re); end
        if (bus.im_out !== '0)             begin tests_failed++; $display("FAIL dc_im: got %0d expected 0", bus.im_out); end
        if (bus.mag_out !== (ACC_W+1)'(exp_mag)) begin tests_failed++; $display("FAIL dc_mag: got %0d expected %0d", bus.mag_out, exp_mag); end
        repeat (3) @(negedge clk);
        tests_run += 3;
        if (bus.done !== 1'b0)             begin tests_failed++; $display("FAIL dc_done_width: done still %b", bus.done); end
        if (bus.busy !== 1'b0)             begin tests_failed++; $display("FAIL dc_idle_busy: got %b expected 0", bus.busy); end
        if (bus.re_out !== ACC_W'(exp_re)) begin tests_failed++; $display("FAIL dc_hold_re: got %0d expected %0d", bus.re_out, exp_re); end
    endtask

    task automatic test_sine_bin1();
        int     lat;
        bit     gd, ra;
        longint er, ei, em, dre, dim;
        for (int n = 0; n < N; n++) smp[n] = sine[n];
        model(1, er, ei, em);
        run_frame(1, 1'b0, 1'b0, lat, gd, ra);
        dre = longint'(bus.re_out);
        dim = longint'(bus.im_out);
        if (dre < 0) dre = -dre;
        tests_run += 5;
        if (!gd || lat != DONE_LAT)        begin tests_failed++; $display("FAIL sin1_done: got latency %0d expected %0d", lat, DONE_LAT); end
        if (bus.re_out !== ACC_W'(er))     begin tests_failed++; $display("FAIL sin1_re: got %0d expected %0d", bus.re_out, er); end
        if (bus.im_out !== ACC_W'(ei))     begin tests_failed++; $display("FAIL sin1_im: got %0d expected %0d", bus.im_out, ei); end
        if (bus.mag_out !== (ACC_W+1)'(em)) begin tests_failed++; $display("FAIL sin1_mag: got %0d expected %0d", bus.mag_out, em); end
        if (dim <= 1000 * dre)             begin tests_failed++; $display("FAIL sin1_dominance: im %0d vs |re| %0d", dim, dre); end
    endtask

    task automatic test_stall_bin5();
        int     lat;
        bit     gd, ra;
        longint er, ei, em;
        fill_random();
        model(5, er, ei, em);
        for (int pass = 0; pass < 2; pass++) begin
            run_frame(5, pass == 1, 1'b0, lat, gd, ra);
            tests_run += 5;
            if (!gd)                         begin tests_failed++; $display("FAIL bin5_done pass%0d: no done pulse", pass); end
            if (ra !== 1'b0)                 begin tests_failed++; $display("FAIL bin5_ready_after pass%0d: got %b expected 0", pass, ra); end
            if (bus.re_out !== ACC_W'(er))   begin tests_failed++; $display("FAIL bin5_re pass%0d: got %0d expected %0d", pass, bus.re_out, er); end
            if (bus.im_out !== ACC_W'(ei))   begin tests_failed++; $display("FAIL bin5_im pass%0d: got %0d expected %0d", pass, bus.im_out, ei); end
            if (bus.mag_out !== (ACC_W+1)'(em)) begin tests_failed++; $display("FAIL bin5_mag pass%0d: got %0d expected %0d", pass, bus.mag_out, em); end
        end
    endtask

    task automatic test_clr();
        int     k, lat, fed, guard;
        bit     gd, ra, saw_done;
        longint er, ei, em;
        fill_random();
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = N_LOG2'(7);
        @(negedge clk);
        bus.start = 1'b0;
        fed = 0; guard = 0;
        while (fed < 1000 && guard < 4000) begin
            bus.in_valid = 1'b1;
            bus.sample   = SIZE'(smp[fed]);
            if (bus.in_ready) fed++;
            @(negedge clk);
            guard++;
        end
        bus.clr    = 1'b1;
        bus.sample = SIZE'(smp[fed]);
        @(negedge clk);
        bus.clr = 1'b0;
        tests_run += 4;
        if (bus.busy !== 1'b0)     begin tests_failed++; $display("FAIL clr_busy: got %b expected 0", bus.busy); end
        if (bus.in_ready !== 1'b0) begin tests_failed++; $display("FAIL clr_in_ready: got %b expected 0", bus.in_ready); end
        if (bus.re_out !== '0)     begin tests_failed++; $display("FAIL clr_re: got %0d expected 0", bus.re_out); end
        if (bus.im_out !== '0)     begin tests_failed++; $display("FAIL clr_im: got %0d expected 0", bus.im_out); end
        saw_done = 1'b0;
        repeat (1100) begin
            @(negedge clk);
            if (bus.done) saw_done = 1'b1;
        end
        bus.in_valid = 1'b0;
        tests_run++;
        if (saw_done) begin tests_failed++; $display("FAIL clr_no_done: got done=1 expected none"); end
        fill_random();
        k = int'($urandom_range(N - 1, 1));
        model(k, er, ei, em);
        run_frame(k, 1'b0, 1'b0, lat, gd, ra);
        tests_run += 3;
        if (!gd || lat != DONE_LAT)    begin tests_failed++; $display("FAIL clr_fresh_done k=%0d: latency %0d expected %0d", k, lat, DONE_LAT); end
        if (bus.re_out !== ACC_W'(er)) begin tests_failed++; $display("FAIL clr_fresh_re k=%0d: got %0d expected %0d", k, bus.re_out, er); end
        if (bus.im_out !== ACC_W'(ei)) begin tests_failed++; $display("FAIL clr_fresh_im k=%0d: got %0d expected %0d", k, bus.im_out, ei); end
    endtask

    task automatic test_rst_mid();
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = N_LOG2'(3);
        @(negedge clk);
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        for (int n = 0; n < 500; n++) begin
            bus.sample = SIZE'(int'($urandom_range(65535, 0)));
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        tests_run += 5;
        if (bus.in_ready !== 1'b0) begin tests_failed++; $display("FAIL rstmid_in_ready: got %b expected 0", bus.in_ready); end
        if (bus.busy !== 1'b0)     begin tests_failed++; $display("FAIL rstmid_busy: got %b expected 0", bus.busy); end
        if (bus.re_out !== '0)     begin tests_failed++; $display("FAIL rstmid_re: got %0d expected 0", bus.re_out); end
        if (bus.im_out !== '0)     begin tests_failed++; $display("FAIL rstmid_im: got %0d expected 0", bus.im_out); end
        if (bus.mag_out !== '0)    begin tests_failed++; $display("FAIL rstmid_mag: got %0d expected 0", bus.mag_out); end
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_start_clr();
        @(negedge clk);
        bus.start = 1'b1;
        bus.clr   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.clr   = 1'b0;
        tests_run += 2;
        if (bus.busy !== 1'b0)     begin tests_failed++; $display("FAIL start_clr_busy: got %b expected 0", bus.busy); end
        if (bus.in_ready !== 1'b0) begin tests_failed++; $display("FAIL start_clr_in_ready: got %b expected 0", bus.in_ready); end
    endtask

    task automatic test_alias_busy_start();
        int     k, lat;
        bit     gd, ra;
        longint er, ei, em;
        fill_random();
        k = N - 1 - int'($urandom_range(N / 2 - 1, 0));
        model(k, er, ei, em);
        run_frame(k, 1'b0, 1'b1, lat, gd, ra);
        tests_run += 4;
        if (!gd || lat != DONE_LAT)      begin tests_failed++; $display("FAIL alias_done k=%0d: latency %0d expected %0d", k, lat, DONE_LAT); end
        if (bus.re_out !== ACC_W'(er))   begin tests_failed++; $display("FAIL alias_re k=%0d: got %0d expected %0d", k, bus.re_out, er); end
        if (bus.im_out !== ACC_W'(ei))   begin tests_failed++; $display("FAIL alias_im k=%0d: got %0d expected %0d", k, bus.im_out, ei); end
        if (bus.mag_out !== (ACC_W+1)'(em)) begin tests_failed++; $display("FAIL alias_mag k=%0d: got %0d expected %0d", k, bus.mag_out, em); end
    endtask

    initial begin
        real x;
        tests_run    = 0;
        tests_failed = 0;
        for (int i = 0; i < N; i++) begin
            x       = 32767.0 * $sin(2.0 * 3.14159265358979323846 * real'(i) / real'(N));
            sine[i] = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
        end
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.clr      = 1'b0;
        bus.bin      = '0;
        bus.in_valid = 1'b0;
        bus.sample   = '0;

        test_reset();
        test_dc();
        test_sine_bin1();
        test_stall_bin5();
        test_clr();
        test_rst_mid();
        test_start_clr();
        test_alias_busy_start();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
